// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the integer register file.
// Optional macro REGFILE_BYPASS_EN is consumed by regfile_core.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int REG_DATA_W = 32;
  localparam int RF_DEPTH   = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks indices 1..DEPTH-1 once per request
// and back-pressures the write port while it runs.
module regfile_clr_fsm
  import regfile_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_ares,
  input  logic                  i_clr_req,
  output logic                  o_wready,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_idx
);

  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

  rf_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_busy;
  logic                  r_wready;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;

  assign w_idx_nxt = r_idx + IDX_ONE;

  always_ff @(posedge i_clk or negedge i_ares) begin
    if (!i_ares) begin
      r_state  <= IDLE;
      r_idx    <= IDX_ONE;
      r_busy   <= 1'b0;
      r_wready <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_clr_req) begin
            r_state  <= CLEAR;
            r_idx    <= IDX_ONE;
            r_busy   <= 1'b1;
            r_wready <= 1'b0;
            r_done   <= (IDX_ONE == IDX_LAST);
          end
        end
        CLEAR: begin
          // final increment wraps to 0 and is never used as a target
          r_idx <= w_idx_nxt;
          if (r_idx == IDX_LAST) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_wready <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_done <= (w_idx_nxt == IDX_LAST);
          end
        end
      endcase
    end
  end

  assign o_wready   = r_wready;
  assign o_clr_busy = r_busy;
  assign o_clr_done = r_done;
  assign o_clr_we   = r_busy;
  assign o_clr_idx  = r_idx;

endmodule

// File: rtl/regfile_core.sv
// 2R1W register file, entry 0 hardwired to zero, with bulk clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_core
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  ares,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [REG_DATA_W-1:0] wdata,
  input  logic                  wen,
  output logic                  wready,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_DATA_W-1:0] rdata1,
  output logic [REG_DATA_W-1:0] rdata2,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  logic [REG_DATA_W-1:0] r_mem [RF_DEPTH];
  logic                  w_wready;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_idx;
  logic                  w_wr_en;

  regfile_clr_fsm u_clr_fsm (
    .i_clk      (clk),
    .i_ares     (ares),
    .i_clr_req  (clr_req),
    .o_wready   (w_wready),
    .o_clr_busy (clr_busy),
    .o_clr_done (clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  assign wready  = w_wready;
  assign w_wr_en = wen & w_wready & (waddr != '0);

  always_ff @(posedge clk or negedge ares) begin
    if (!ares) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = r_mem[raddr1];
    if (raddr2 != '0) rdata2 = r_mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (w_wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: tb/tb_regfile_core.sv
// Randomized self-checking bench for regfile_core against an array model.
module tb_regfile_core;

  logic        clk = 1'b0;
  logic        ares;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        wready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [32];

  regfile_core dut (
    .clk      (clk),
    .ares     (ares),
    .waddr    (waddr),
    .wdata    (wdata),
    .wen      (wen),
    .wready   (wready),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic test_reset();
    ares = 1'b0; wen = 0; clr_req = 0;
    waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
    model_clear();
    repeat (2) @(negedge clk);
    ares = 1'b1;
    @(negedge clk);
    checks++;
    if (wready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got wready=%b busy=%b done=%b want 1 0 0",
               wready, clr_busy, clr_done);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
        failures++;
        $display("FAIL reset_read idx=%0d got %h/%h want 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1; waddr = a; wdata = d;
    @(posedge clk);
    if (a != 0) model[a] = d;
    @(negedge clk);
    wen = 0;
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    raddr1 = 5; raddr2 = 5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read5 got %h/%h want deadbeef", rdata1, rdata2);
    end
  endtask

  task automatic test_write_zero();
    do_write(5'd0, 32'hFFFFFFFF);
    raddr1 = 0; raddr2 = 0;
    #1;
    checks++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      failures++;
      $display("FAIL write_zero got %h/%h want 0", rdata1, rdata2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] e1, e2;
      @(negedge clk);
      wen    = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom);
      wdata  = $urandom;
      raddr1 = 5'($urandom);
      raddr2 = (n % 7 == 0) ? raddr1 : 5'($urandom);
      #1;
      e1 = model[raddr1];
      e2 = model[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (wen && waddr != 0 && waddr == raddr1) e1 = wdata;
      if (wen && waddr != 0 && waddr == raddr2) e2 = wdata;
`endif
      checks++;
      if (rdata1 !== e1 || rdata2 !== e2 || wready !== 1'b1) begin
        failures++;
        $display("FAIL random_read n=%0d a=%0d/%0d got %h/%h wr=%b want %h/%h wr=1",
                 n, raddr1, raddr2, rdata1, rdata2, wready, e1, e2);
      end
      @(posedge clk);
      if (wen && waddr != 0) model[waddr] = wdata;
    end
    @(negedge clk);
    wen = 0;
  endtask

  task automatic fill_own_index();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
  endtask

  task automatic test_clear();
    int busy_cnt = 0, done_cnt = 0, done_at = 0, cyc = 0;
    fill_own_index();
    raddr1 = 3; raddr2 = 31;
    #1;
    checks++;
    if (rdata1 !== 32'd3 || rdata2 !== 32'd31) begin
      failures++;
      $display("FAIL fill_check got %h/%h want 3/1f", rdata1, rdata2);
    end
    @(negedge clk);
    clr_req = 1;
    @(posedge clk);
    model_clear();
    do begin
      @(negedge clk);
      clr_req = (cyc == 5);
      wen = 0;
      if (clr_busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_at = busy_cnt; end
      if (clr_busy && busy_cnt == 10) begin
        wen = 1; waddr = 3; wdata = 32'h1234;
        checks++;
        if (wready !== 1'b0) begin
          failures++;
          $display("FAIL clear_wready got %b want 0", wready);
        end
      end
      cyc++;
      @(posedge clk);
    end while (clr_busy && cyc < 60);
    @(negedge clk);
    wen = 0; clr_req = 0;
    checks++;
    if (busy_cnt != 31 || done_cnt != 1 || done_at != 31) begin
      failures++;
      $display("FAIL clear_timing got busy=%0d done=%0d at=%0d want 31 1 31",
               busy_cnt, done_cnt, done_at);
    end
    @(negedge clk);
    checks++;
    if (wready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_after got wr=%b busy=%b done=%b want 1 0 0",
               wready, clr_busy, clr_done);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      checks++;
      if (rdata1 !== model[i] || rdata2 !== model[i]) begin
        failures++;
        $display("FAIL clear_read idx=%0d got %h/%h want %h",
                 i, rdata1, rdata2, model[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt = 0, dones = 0;
    fill_own_index();
    @(negedge clk);
    clr_req = 1;
    @(posedge clk);
    for (int c = 0; c < 40 && busy_cnt < 12; c++) begin
      @(negedge clk);
      clr_req = 0;
      if (clr_busy) busy_cnt++;
      if (clr_done) dones++;
    end
    ares = 1'b0;
    model_clear();
    #1;
    checks++;
    if (busy_cnt != 12 || wready !== 1'b1 || clr_busy !== 1'b0 ||
        clr_done !== 1'b0) begin
      failures++;
      $display("FAIL midclr_flags got n=%0d wr=%b busy=%b done=%b want 12 1 0 0",
               busy_cnt, wready, clr_busy, clr_done);
    end
    @(negedge clk);
    ares = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (clr_done || clr_busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midclr_done got %0d want 0", dones);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata1 !== model[i] || rdata2 !== model[31 - i]) begin
        failures++;
        $display("FAIL midclr_read idx=%0d got %h/%h want 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old, e1;
    old = $urandom;
    do_write(5'd7, old);
    @(negedge clk);
    wen = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr1 = 7; raddr2 = 8;
    #1;
`ifdef REGFILE_BYPASS_EN
    e1 = 32'hA5A5A5A5;
`else
    e1 = old;
`endif
    checks++;
    if (rdata1 !== e1 || rdata2 !== model[8]) begin
      failures++;
      $display("FAIL bypass_same got %h/%h want %h/%h", rdata1, rdata2, e1, model[8]);
    end
    @(posedge clk);
    model[7] = 32'hA5A5A5A5;
    @(negedge clk);
    wen = 0;
    #1;
    checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_next got %h want a5a5a5a5", rdata1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_zero();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_core.md
# regfile_core

Two-read, one-write integer register file that answers the requests driven by `regfile_if`: clocked writes, combinational reads on two independent ports. Entry 0 is hardwired to zero. A bulk-clear sequencer zeroes the array one entry per cycle on request and back-pressures writes while it runs. Sits in the RISC-V core between decode (read ports) and writeback (write port).

## Interface
- `ADDR_WIDTH`, 5, register index width; depth = 2^ADDR_WIDTH
- `REG_DATA_W`, 32, register data width
- `clk`  in  1  core clock; all state changes on rising edge
- `ares`  in  1  reset, asynchronous, active-low
- `waddr`  in  ADDR_WIDTH  write index
- `wdata`  in  REG_DATA_W  write data
- `wen`  in  1  write enable, sampled at rising edge
- `wready`  out  1  write accepted this cycle when high
- `raddr1`, `raddr2`  in  ADDR_WIDTH  read indices
- `rdata1`, `rdata2`  out  REG_DATA_W  read data, combinational
- `clr_req`  in  1  start bulk clear, sampled at rising edge
- `clr_busy`  out  1  clear sequence in progress
- `clr_done`  out  1  one-cycle pulse on the last clear cycle

## Operation
- Reset (`ares`=0): all entries 0, FSM in IDLE, `wready`=1, `clr_busy`=0, `clr_done`=0, clear index = 1.
- Write: at a rising edge with `wen`=1, `wready`=1 and `waddr`!=0, entry[`waddr`] <= `wdata`. Writes to index 0 are discarded.
- Write with `wready`=0 is dropped. There is no queueing, and the writer must retry.
- Read: `rdataN` = entry[`raddrN`]. Index 0 always returns 0. Both ports are fully independent, and identical addresses on both ports are legal.
- FSM states:
  - IDLE: `wready`=1, `clr_busy`=0.
    - `clr_req`=1 -> CLEAR. The index register is loaded with 1.
    - A simultaneous `wen` in the same cycle is still committed.
  - CLEAR: `wready`=0, `clr_busy`=1.
    - Each cycle, entry[index] <= 0 and index increments.
    - When index = 2^ADDR_WIDTH-1, that entry is cleared, `clr_done`=1 for that cycle, and the FSM returns to IDLE next cycle.
    - `clr_req` is ignored while in CLEAR.
- Reads during CLEAR return current array contents, a mix of cleared and not-yet-cleared entries.
- Index width is ADDR_WIDTH. The final increment wraps to 0 and is never used as a target.

## Timing
- Write latency: data is visible on the read ports from the cycle after the accepting edge; same-cycle visibility is available only with bypass (see Configuration).
- Read latency: 0 cycles, purely combinational from `raddrN` and array state.
- Clear duration: exactly 2^ADDR_WIDTH-1 cycles with `clr_busy`=1 (31 for the default).
  - `wready` drops on the first CLEAR cycle and rises on the cycle after `clr_done`.
- `ares` asserted mid-clear: immediate return to IDLE with all entries 0, and no `clr_done` pulse.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read port returns `wdata` instead of array contents when all of these hold in the same cycle:
  - `wen`=1 and `wready`=1
  - `waddr` = `raddrN`
  - `waddr` != 0
- Without `REGFILE_BYPASS_EN`: reads return only the stored array value, and a same-cycle write is visible the next cycle.

## Structure
- `regfile_pkg`: `ADDR_WIDTH`, `REG_DATA_W`, and the FSM state enum typedef (`IDLE`, `CLEAR`).
- One sub-module, `regfile_clr_fsm`:
  - Contains the state register, clear index counter, and `clr_busy`/`clr_done`/`wready` generation.
  - Outputs the clear index and clear-write-enable to the array.
- The top level holds the array, write mux, and read/bypass muxes.

## Test plan
- Reset, then read all 32 indices on both ports -> every `rdata` = 0; `wready`=1, `clr_busy`=0.
- Write 0xDEADBEEF to index 5, then read index 5 on port 1 and port 2 the following cycle -> both return 0xDEADBEEF.
- Write 0xFFFFFFFF to index 0, then read index 0 -> 0.
- Fill indices 1-31 with their own index value, pulse `clr_req` -> `clr_busy` high for 31 cycles and `clr_done` on the 31st; a write of 0x1234 to index 3 at cycle 10 is dropped; afterwards all reads = 0.
- Assert `ares` at CLEAR cycle 12 -> FSM returns to IDLE, `wready`=1, all entries 0, no `clr_done` pulse.
- With `REGFILE_BYPASS_EN`, write 0xA5A5A5A5 to index 7 while `raddr1`=7 -> `rdata1`=0xA5A5A5A5 in the same cycle. Without the macro -> old value that cycle, new value next cycle.
